// File: rtl/sfence_sweep.sv
// sfence_sweep: walks a sync-read TLB tag array one entry per cycle, invalidating sfence.vma matches
package sfence_sweep_pkg;
  typedef struct packed {
    int unsigned XLEN;
  } cvw_t;
endpackage

module sfence_sweep
  import sfence_sweep_pkg::*;
#(
  parameter cvw_t P = '{XLEN: 64},
  parameter int ENTRIES = 32,
  parameter int VPN_BITS = 27,
  parameter int ASID_BITS = 16,
  localparam int IW = $clog2(ENTRIES)
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SfenceReqM,
  input  logic                 StallM,
  input  logic                 FlushM,
  input  logic                 Rs1ZeroM,
  input  logic                 Rs2ZeroM,
  input  logic [P.XLEN-1:0]    VAddrM,
  input  logic [ASID_BITS-1:0] ASIDM,
  output logic                 EntryReadEn,
  output logic [IW-1:0]        EntryIdx,
  input  logic                 EntryValid,
  input  logic                 EntryGlobal,
  input  logic [VPN_BITS-1:0]  EntryVPN,
  input  logic [ASID_BITS-1:0] EntryASID,
  input  logic [1:0]           EntryPageType,
  output logic                 InvalEn,
  output logic [IW-1:0]        InvalIdx,
  output logic                 FlushAllM,
  output logic                 SweepStallM,
  output logic                 SweepDone
);
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
  state_t                r_state, w_next;
  logic [IW-1:0]         r_cnt, r_idx;
  logic [VPN_BITS-1:0]   r_vpn, w_mask;
  logic [ASID_BITS-1:0]  r_asid;
  logic                  r_rs1z, r_rs2z, r_flushall, r_rdvld, r_first;
  logic                  w_accept, w_addr_match, w_asid_match, w_unused;
  assign w_accept = (r_state == IDLE) & SfenceReqM & ~FlushM;
  assign w_unused = ^{VAddrM[P.XLEN-1:12+VPN_BITS], VAddrM[11:0]};
  assign w_mask = {VPN_BITS{1'b1}} << (5'd9 * {3'b0, EntryPageType});
  assign w_addr_match = r_rs1z | (((r_vpn ^ EntryVPN) & w_mask) == '0);
  assign w_asid_match = r_rs2z | (~EntryGlobal & (r_asid == EntryASID));
  // state register
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  // next state: any flush outside IDLE abandons the sweep
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? ((Rs1ZeroM & Rs2ZeroM) ? DONE : SWEEP) : IDLE;
      SWEEP:   w_next = FlushM ? IDLE : (r_cnt == IW'(ENTRIES - 1)) ? DRAIN : SWEEP;
      DRAIN:   w_next = FlushM ? IDLE : DONE;
      default: w_next = (FlushM | ~StallM) ? IDLE : DONE;
    endcase
  end
  // walk counter, compare-stage pipeline and captured fence operands
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rdvld    <= 1'b0;
      r_first    <= 1'b0;
      r_vpn      <= '0;
      r_asid     <= '0;
      r_rs1z     <= 1'b0;
      r_rs2z     <= 1'b0;
      r_flushall <= 1'b0;
    end else begin
      r_cnt   <= (r_state == SWEEP && w_next == SWEEP) ? r_cnt + 1'b1 : '0;
      r_rdvld <= (r_state == SWEEP) & ~FlushM;
      r_idx   <= r_cnt;
      r_first <= r_state != DONE;
      if (w_accept) begin
        r_vpn      <= VAddrM[12+VPN_BITS-1:12];
        r_asid     <= ASIDM;
        r_rs1z     <= Rs1ZeroM;
        r_rs2z     <= Rs2ZeroM;
        r_flushall <= Rs1ZeroM & Rs2ZeroM;
      end else if (r_state == DONE && w_next == IDLE) r_flushall <= 1'b0;
    end
  end
  // outputs decoded from state and the compare stage
  always_comb begin
    EntryReadEn = r_state == SWEEP;
    EntryIdx    = r_cnt;
    InvalEn     = r_rdvld & EntryValid & w_addr_match & w_asid_match;
    InvalIdx    = r_idx;
    SweepDone   = r_state == DONE;
    FlushAllM   = (r_state == DONE) & r_flushall & r_first;
    SweepStallM = SfenceReqM & ~FlushM & (r_state != DONE);
  end
endmodule

// File: tb/tb_sfence_sweep.sv
// tb_sfence_sweep: directed and randomized fences checked cycle by cycle against a tag-array reference model
module tb_sfence_sweep;
  localparam int N = 32, VB = 27, AB = 16;
  logic clk = 1'b0, reset, SfenceReqM, StallM, FlushM, Rs1ZeroM, Rs2ZeroM;
  logic [63:0] VAddrM;
  logic [AB-1:0] ASIDM, EntryASID;
  logic EntryReadEn, EntryValid, EntryGlobal, InvalEn, FlushAllM, SweepStallM, SweepDone;
  logic [4:0] EntryIdx, InvalIdx;
  logic [VB-1:0] EntryVPN;
  logic [1:0] EntryPageType;
  logic t_v[N], t_g[N];
  logic [VB-1:0] t_vpn[N];
  logic [AB-1:0] t_asid[N];
  logic [1:0] t_pt[N];
  int vectors = 0, errors = 0;

  sfence_sweep #(.ENTRIES(N), .VPN_BITS(VB), .ASID_BITS(AB)) dut (
    .clk(clk), .reset(reset), .SfenceReqM(SfenceReqM), .StallM(StallM), .FlushM(FlushM),
    .Rs1ZeroM(Rs1ZeroM), .Rs2ZeroM(Rs2ZeroM), .VAddrM(VAddrM), .ASIDM(ASIDM),
    .EntryReadEn(EntryReadEn), .EntryIdx(EntryIdx), .EntryValid(EntryValid), .EntryGlobal(EntryGlobal),
    .EntryVPN(EntryVPN), .EntryASID(EntryASID), .EntryPageType(EntryPageType),
    .InvalEn(InvalEn), .InvalIdx(InvalIdx), .FlushAllM(FlushAllM), .SweepStallM(SweepStallM),
    .SweepDone(SweepDone)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (EntryReadEn) begin
      EntryValid    <= t_v[EntryIdx];
      EntryGlobal   <= t_g[EntryIdx];
      EntryVPN      <= t_vpn[EntryIdx];
      EntryASID     <= t_asid[EntryIdx];
      EntryPageType <= t_pt[EntryIdx];
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(int i, bit r1, bit r2, logic [63:0] va, logic [AB-1:0] as);
    int sh;
    logic [VB-1:0] want;
    sh = 9 * int'(t_pt[i]);
    want = va[38:12];
    return t_v[i] && (r1 || (want >> sh) == (t_vpn[i] >> sh)) && (r2 || (!t_g[i] && t_asid[i] == as));
  endfunction

  task automatic drive_idle();
    SfenceReqM = 0; StallM = 0; FlushM = 0; Rs1ZeroM = 0; Rs2ZeroM = 0; VAddrM = '0; ASIDM = '0;
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive_idle();
      #1;
      chk("idle_stall", SweepStallM, 0);
      chk("idle_rden", EntryReadEn, 0);
      chk("idle_inval", InvalEn, 0);
      chk("idle_done", SweepDone, 0);
      chk("idle_flushall", FlushAllM, 0);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) begin
      t_v[i] = 0; t_g[i] = 0; t_vpn[i] = '0; t_asid[i] = '0; t_pt[i] = '0;
    end
  endtask

  task automatic fill_random(input logic [VB-1:0] base);
    for (int i = 0; i < N; i++) begin
      t_v[i]    = ($urandom % 4) != 0;
      t_g[i]    = ($urandom % 4) == 0;
      t_asid[i] = AB'($urandom % 4);
      t_pt[i]   = 2'($urandom % 4);
      t_vpn[i]  = base ^ VB'(($urandom % 2) != 0 ? $urandom % 2048 : $urandom % (1 << 20));
    end
  endtask

  task automatic fence(input bit r1, input bit r2, input logic [63:0] va, input logic [AB-1:0] as,
                       input int hold, input int abort_c);
    bit both, live, exp_rd, exp_inv;
    int d, last;
    both = r1 && r2;
    d = both ? 1 : N + 2;
    last = (abort_c > 0) ? abort_c + 3 : d + hold + 1;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      live = !(abort_c > 0 && c > abort_c);
      SfenceReqM = live && c <= d + hold;
      FlushM = abort_c > 0 && c == abort_c;
      StallM = live && c >= d && c < d + hold;
      Rs1ZeroM = r1; Rs2ZeroM = r2; VAddrM = va; ASIDM = as;
      #1;
      if (FlushM) begin
        chk("abort_stall", SweepStallM, 0);
        chk("abort_done", SweepDone, 0);
      end else begin
        exp_rd = live && !both && c >= 1 && c <= N;
        exp_inv = live && !both && c >= 2 && c <= N + 1 && model_hit(c - 2, r1, r2, va, as);
        chk("stall", SweepStallM, live && c < d);
        chk("rden", EntryReadEn, exp_rd);
        if (exp_rd) chk("rdidx", EntryIdx, 64'(c - 1));
        chk("inval", InvalEn, exp_inv);
        if (exp_inv) chk("invidx", InvalIdx, 64'(c - 2));
        chk("done", SweepDone, live && c >= d && c <= d + hold);
        chk("flushall", FlushAllM, live && both && c == d);
      end
    end
    drive_idle();
  endtask

  initial begin
    logic [VB-1:0] base;
    int sel;
    reset = 1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    idle_check(5);

    clear_table();
    fence(1, 1, 64'h0, '0, 0, 0);
    fence(1, 1, 64'h1234_5000, 16'h7, 3, 0);

    clear_table();
    t_v[3] = 1; t_g[3] = 0; t_asid[3] = 5;
    t_v[7] = 1; t_g[7] = 1; t_asid[7] = 5;
    t_v[9] = 1; t_g[9] = 0; t_asid[9] = 4;
    fence(1, 0, 64'h0, 16'd5, 0, 0);

    clear_table();
    t_v[10] = 1; t_pt[10] = 1; t_vpn[10] = 27'h40210;
    t_v[11] = 1; t_pt[11] = 0; t_vpn[11] = 27'h40201;
    fence(0, 1, 64'h4020_0000, '0, 2, 0);

    for (int k = 0; k < 6; k++) begin
      base = VB'($urandom);
      fill_random(base);
      sel = $urandom % 3;
      fence(sel == 1, sel == 2, {25'($urandom), base, 12'($urandom)}, AB'($urandom % 4), k == 0 ? 3 : $urandom % 3, 0);
    end

    base = VB'($urandom);
    fill_random(base);
    fence(0, 1, {25'h0, base, 12'h0}, '0, 0, 11);
    idle_check(2);

    @(negedge clk);
    SfenceReqM = 1; FlushM = 1; Rs1ZeroM = 1; Rs2ZeroM = 1;
    #1;
    chk("idle_flush_stall", SweepStallM, 0);
    idle_check(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/sfence_sweep.md
# sfence_sweep

Sequential responder for decoded `sfence.vma` and Svinval requests in the M stage. It walks a synchronous-read TLB tag array one entry per cycle and invalidates every entry matching the requested virtual page and ASID. It stalls the pipeline until the walk completes. It sits between the privileged-instruction decoder (`sfencevmaM`) and a large, SRAM-based TLB that cannot be flushed selectively in a single cycle.

## Interface
Parameters:
- `P`, cvw_t config; supplies `XLEN`.
- `ENTRIES`, 32: TLB entries; power of 2, at least 2.
- `VPN_BITS`, 27: VPN width, arranged as 9-bit segments; Sv39 = 27.
- `ASID_BITS`, 16: ASID width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `SfenceReqM`  in  1  decoded sfence.vma or Svinval in M; held high while the instruction stalls.
- `StallM`  in  1  external M-stage stall, excluding this block's own stall.
- `FlushM`  in  1  M-stage flush (trap or interrupt).
- `Rs1ZeroM`, `Rs2ZeroM`  in  1 each  rs1 or rs2 field is x0.
- `VAddrM`  in  XLEN  rs1 value; VPN = `VAddrM[12+VPN_BITS-1:12]`.
- `ASIDM`  in  ASID_BITS  rs2 low bits.
- `EntryReadEn`  out  1  tag-array read strobe.
- `EntryIdx`  out  log2(ENTRIES)  read index.
- `EntryValid`, `EntryGlobal`  in  1 each  read data, returned the cycle after the read.
- `EntryVPN`  in  VPN_BITS  read data.
- `EntryASID`  in  ASID_BITS  read data.
- `EntryPageType`  in  2  0 = 4 KiB, 1 = 2 MiB, 2 = 1 GiB, 3 = 512 GiB.
- `InvalEn`  out  1  clear the valid bit of entry `InvalIdx`.
- `InvalIdx`  out  log2(ENTRIES)  index to invalidate.
- `FlushAllM`  out  1  one-cycle clear of all valid bits.
- `SweepStallM`  out  1  hold the pipeline.
- `SweepDone`  out  1  sweep complete; the instruction may retire.

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- Reset:
  - State goes to IDLE and the index counter clears to 0.
  - The compare-stage valid flag clears.
  - All outputs are 0.
- IDLE:
  - On `SfenceReqM & ~FlushM`, capture VPN, `ASIDM`, `Rs1ZeroM` and `Rs2ZeroM`.
  - If both zero flags are set, go to DONE with the FlushAll flag set.
  - Otherwise go to SWEEP with the counter at 0.
- SWEEP:
  - `EntryReadEn` = 1 and `EntryIdx` = counter.
  - The counter increments each cycle.
  - At `ENTRIES-1`, go to DRAIN. The counter wraps to 0.
- DRAIN: no read; the last entry is compared. Next state is DONE.
- Compare stage:
  - Registered read-valid and registered index (`InvalIdx`).
  - `InvalEn` = RdVld & `EntryValid` & AddrMatch & AsidMatch.
- AddrMatch:
  - True if Rs1Zero.
  - Otherwise VPN equals `EntryVPN`, ignoring the low 9×`EntryPageType` bits.
- AsidMatch:
  - True if Rs2Zero.
  - Otherwise `~EntryGlobal & (ASID == EntryASID)`. Global entries are never flushed by an ASID-specific fence.
- DONE:
  - `SweepDone` = 1 and `FlushAllM` = FlushAll flag.
  - Stay in DONE while `StallM`. `FlushAllM` asserts only in the first DONE cycle.
  - Go to IDLE when `~StallM`. The flag clears.
- `SweepStallM` = `SfenceReqM & ~FlushM & (state != DONE)`.
- `FlushM` in any non-IDLE state:
  - Go to IDLE next cycle and drop RdVld.
  - No further `InvalEn` or `SweepDone`.
  - Invalidations already issued stand; over-invalidation is architecturally safe.
- Simultaneous `FlushM` and request in IDLE: the request is ignored.
- In DONE, a still-high `SfenceReqM` is the retiring instruction and does not start a new sweep. A back-to-back fence is accepted in the following IDLE cycle.

## Timing
- Selective fence, request seen at cycle 0:
  - Entry i is read in cycle i+1. `InvalEn` for entry i, if it matches, is in cycle i+2.
  - DRAIN is at cycle ENTRIES+1 and DONE at cycle ENTRIES+2.
  - `SweepStallM` is high for ENTRIES+2 cycles (cycles 0..ENTRIES+1).
- Flush-all: stall in cycle 0 only; `FlushAllM` and `SweepDone` are high in cycle 1.
- At most one `InvalEn` per cycle.
- `EntryReadEn` is never high outside SWEEP.
- Tag data is sampled exactly one cycle after the read.

## Test plan
- **Reset:** assert reset 2 cycles, then request idle for 5 cycles. All outputs stay 0 and the state is IDLE.
- **Flush-all:** `Rs1ZeroM`=`Rs2ZeroM`=1. `SweepStallM` is high in cycle 0. `FlushAllM` and `SweepDone` are high in cycle 1. `InvalEn` never asserts.
- **ASID-only** (ENTRIES=32): `Rs1ZeroM`=1, `ASIDM`=5. Entry 3 is ASID 5 non-global, entry 7 is ASID 5 global, entry 9 is ASID 4.
  - Exactly one `InvalEn`, with `InvalIdx`=3 in cycle 5.
  - Stall lasts 34 cycles. `SweepDone` asserts in cycle 34.
- **Superpage:** `VAddrM`=0x40200000, `Rs2ZeroM`=1.
  - Entry 10: 2 MiB page, VPN 0x40200 with low 9 bits differing (0x40210). It is invalidated in cycle 12.
  - Entry 11: 4 KiB page, VPN 0x40201. It is not invalidated.
- **Abort:** `FlushM` at SWEEP counter 10. State returns to IDLE next cycle, with no further `InvalEn` and no `SweepDone`.
- **Held DONE:** `StallM` high for 3 cycles on reaching DONE. `SweepDone` stays high 3+1 cycles, `SweepStallM` stays 0, and `FlushAllM` (flush-all case) asserts only in the first cycle.
